wishbone_arbiter: RTL and testbench

Parametrised N-to-1 Wishbone arbiter merging several CPU-side master ports (instruction fetch, data memory, future DMA or debug ports) onto one memory or interconnect port. A granted master keeps the bus for its whole `cyc` cycle. Arbitration is round-robin or fixed-priority, selected at compile time. A per-grant watchdog terminates stalled cycles with an error response.

---
 rtl/wishbone_arbiter_if.sv | 23 ++
 rtl/wishbone_arbiter.sv | 154 +++++++++++++++
 tb/tb_wishbone_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_arbiter_if.sv
// Pipelined Wishbone B4 bus bundle shared by the arbiter's upstream and downstream ports.
interface wishbone_interface;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_mosi;
    logic [31:0] dat_miso;
    logic        ack;
    logic        err;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_mosi,
        input  dat_miso, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_mosi,
        output dat_miso, ack, err, stall
    );
endinterface

// File: rtl/wishbone_arbiter.sv
// N-to-1 Wishbone arbiter with per-grant watchdog. Fixed priority by default;
// define WB_ARBITER_ROUND_ROBIN_EN for round-robin arbitration.
//   state   | meaning
//   IDLE    | no grant, picking a winner among requesters
//   GRANT   | granted master routed combinationally to the slave port
//   TIMEOUT | watchdog fired; slave cut off until the master drops cyc
module wishbone_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    wishbone_interface.slave       masters [NUM_MASTERS],
    wishbone_interface.master      slave,
    output logic [NUM_MASTERS-1:0] grant_out,
    output logic                   timeout_out
);
    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, TIMEOUT} state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       grant_idx, win_idx;
    logic [WD_W-1:0]        wd_cnt;
    logic                   wd_clear, wd_fire;
    logic [NUM_MASTERS-1:0] req, m_stb, m_we;
    logic [31:0]            m_adr [NUM_MASTERS];
    logic [31:0]            m_dat [NUM_MASTERS];
    logic [3:0]             m_sel [NUM_MASTERS];
    logic                   g_cyc;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_up
        logic routed, timed_out;
        assign routed    = (state == GRANT)   && (grant_idx == IDX_W'(i));
        assign timed_out = (state == TIMEOUT) && (grant_idx == IDX_W'(i));

        assign req[i]   = masters[i].cyc;
        assign m_stb[i] = masters[i].stb;
        assign m_we[i]  = masters[i].we;
        assign m_adr[i] = masters[i].adr;
        assign m_sel[i] = masters[i].sel;
        assign m_dat[i] = masters[i].dat_mosi;

        assign masters[i].dat_miso = routed ? slave.dat_miso : '0;
        assign masters[i].ack      = routed ? slave.ack : 1'b0;
        // err on the first TIMEOUT cycle only, which is exactly when timeout_out is high
        assign masters[i].err      = routed ? slave.err : (timed_out && timeout_out);
        assign masters[i].stall    = routed ? slave.stall : 1'b1;
    end

    assign g_cyc = req[grant_idx];

`ifdef WB_ARBITER_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr, next_ptr;
    logic [IDX_W:0]   cand;
    logic             win_found;

    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(NUM_MASTERS))
                cand = cand - (IDX_W+1)'(NUM_MASTERS);
            if (!win_found && req[cand[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign next_ptr = (grant_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst)
            rr_ptr <= '0;
        else if (state != IDLE && state_nxt == IDLE)
            rr_ptr <= next_ptr;
    end
`else
    always_comb begin
        win_idx = '0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--)
            if (req[k]) win_idx = IDX_W'(k);
    end
`endif

    always_comb begin
        state_nxt = state;
        wd_clear  = 1'b0;
        wd_fire   = 1'b0;
        case (state)
            IDLE:    if (|req) state_nxt = GRANT;
            GRANT: begin
                // release and a slave response both take precedence over the watchdog
                if (!g_cyc)
                    state_nxt = IDLE;
                else if (slave.ack || slave.err)
                    wd_clear = 1'b1;
                else if (TIMEOUT_CYCLES != 0 && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    wd_fire   = 1'b1;
                    state_nxt = TIMEOUT;
                end
            end
            TIMEOUT: if (!g_cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        slave.cyc      = 1'b0;
        slave.stb      = 1'b0;
        slave.we       = 1'b0;
        slave.adr      = '0;
        slave.sel      = '0;
        slave.dat_mosi = '0;
        if (state == GRANT) begin
            slave.cyc      = g_cyc;
            slave.stb      = m_stb[grant_idx];
            slave.we       = m_we[grant_idx];
            slave.adr      = m_adr[grant_idx];
            slave.sel      = m_sel[grant_idx];
            slave.dat_mosi = m_dat[grant_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant_idx   <= '0;
            grant_out   <= '0;
            wd_cnt      <= '0;
            timeout_out <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_out <= wd_fire;
            if (state == IDLE && state_nxt == GRANT) begin
                grant_idx <= win_idx;
                grant_out <= NUM_MASTERS'(1) << win_idx;
                wd_cnt    <= '0;
            end else if (state != IDLE && state_nxt == IDLE) begin
                grant_out <= '0;
            end
            if (state == GRANT) begin
                if (wd_clear)
                    wd_cnt <= '0;
                else if (wd_cnt != '1)
                    wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter (3 masters, watchdog of 4 cycles) with a read-data scoreboard.
module tb_wishbone_arbiter;
    localparam int NM = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NM-1:0] m_cyc, m_stb, m_we, m_ack, m_err, m_stall;
    logic [31:0]   m_adr   [NM];
    logic [31:0]   m_dmosi [NM];
    logic [31:0]   m_dmiso [NM];
    logic [3:0]    m_sel   [NM];
    logic          s_ack, s_err, s_stall, s_cyc, s_stb;
    logic [31:0]   s_dmiso, s_adr;
    logic [NM-1:0] gnt;
    logic          to;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] exp_q[$];

    wishbone_interface m_if [NM] ();
    wishbone_interface s_if ();

    for (genvar g = 0; g < NM; g++) begin : g_m
        assign m_if[g].cyc      = m_cyc[g];
        assign m_if[g].stb      = m_stb[g];
        assign m_if[g].we       = m_we[g];
        assign m_if[g].adr      = m_adr[g];
        assign m_if[g].sel      = m_sel[g];
        assign m_if[g].dat_mosi = m_dmosi[g];
        assign m_ack[g]         = m_if[g].ack;
        assign m_err[g]         = m_if[g].err;
        assign m_stall[g]       = m_if[g].stall;
        assign m_dmiso[g]       = m_if[g].dat_miso;
    end

    assign s_if.ack      = s_ack;
    assign s_if.err      = s_err;
    assign s_if.stall    = s_stall;
    assign s_if.dat_miso = s_dmiso;
    assign s_cyc         = s_if.cyc;
    assign s_stb         = s_if.stb;
    assign s_adr         = s_if.adr;

    wishbone_arbiter #(.NUM_MASTERS(NM), .TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .masters     (m_if),
        .slave       (s_if),
        .grant_out   (gnt),
        .timeout_out (to)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_data(input string tag, input int m);
        logic [31:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        chk(tag, m_dmiso[m], e);
    endtask

    initial begin
        int          w;
        int          ptr;
        logic [31:0] d;

        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0;
        for (int i = 0; i < NM; i++) begin
            m_adr[i] = '0; m_sel[i] = 4'hF; m_dmosi[i] = '0;
        end
        s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0; s_dmiso = '0;

        // reset with fetch requesting
        m_cyc[0] = 1'b1;
        nxt();
        chk("rst_gnt", gnt, 0);
        chk("rst_scyc", s_cyc, 0);
        chk("rst_to", to, 0);
        nxt();
        chk("rst_gnt2", gnt, 0);
        chk("rst_scyc2", s_cyc, 0);
        rst = 1'b0;
        nxt();
        chk("rel_gnt", gnt, 3'b001);
        chk("rel_scyc", s_cyc, 1);
        m_cyc[0] = 1'b0;
        nxt();
        chk("rel_idle", gnt, 0);

        // single read by master 1, ack two cycles after stb
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_adr[1] = 32'h0000_1000;
        exp_q.push_back(32'hDEAD_BEEF);
        nxt();
        chk("rd_gnt", gnt, 3'b010);
        chk("rd_sstb", s_stb, 1);
        chk("rd_sadr", s_adr, 32'h0000_1000);
        chk("rd_m0_stall", m_stall[0], 1);
        m_stb[1] = 1'b0;
        nxt();
        chk("rd_m0_stall_w", m_stall[0], 1);
        nxt();
        s_ack = 1'b1; s_dmiso = 32'hDEAD_BEEF;
        #1;
        chk("rd_ack", m_ack[1], 1);
        check_data("rd_data", 1);
        chk("rd_m0_ack", m_ack[0], 0);
        chk("rd_m0_dat", m_dmiso[0], 0);
        chk("rd_m0_stall_a", m_stall[0], 1);
        nxt();
        s_ack = 1'b0; s_dmiso = '0; m_cyc[1] = 1'b0;
        nxt();
        chk("rd_idle", gnt, 0);

        // reset mid-transfer: no ack forwarded afterwards
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
        nxt();
        chk("mr_gnt", gnt, 3'b010);
        s_ack = 1'b1; rst = 1'b1;
        nxt();
        chk("mr_gnt_rst", gnt, 0);
        chk("mr_ack", m_ack[1], 0);
        chk("mr_scyc", s_cyc, 0);
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = 1'b0; rst = 1'b0;
        nxt();

        // contention: all three request and re-request right after each release
        ptr = 0;
        m_cyc = 3'b111;
        nxt();
        for (int k = 0; k < 4; k++) begin
`ifdef WB_ARBITER_ROUND_ROBIN_EN
            w   = ptr;
            ptr = (ptr + 1) % NM;
`else
            w = ptr;
`endif
            chk("cont_gnt", gnt, 32'(1) << w);
            chk("cont_m2_gnt", gnt[2], (w == 2) ? 1 : 0);
            m_stb[w] = 1'b1; m_adr[w] = 32'h2000 + 32'(k);
            d = 32'hC0DE_0000 + 32'(k * 16 + w);
            exp_q.push_back(d);
            s_dmiso = d; s_ack = 1'b1;
            #1;
            chk("cont_ack", m_ack[w], 1);
            check_data("cont_data", w);
            chk("cont_loser_stall", m_stall[(w + 1) % NM], 1);
            nxt();
            m_stb[w] = 1'b0; s_ack = 1'b0; s_dmiso = '0; m_cyc[w] = 1'b0;
            nxt();
            chk("cont_gap", gnt, 0);
            m_cyc[w] = 1'b1;
            nxt();
        end
        m_cyc = '0;
        nxt();
        chk("cont_idle", gnt, 0);

        // watchdog: slave never responds to master 0
        s_stall = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        nxt();
        chk("to_gnt", gnt, 3'b001);
        for (int c = 1; c <= 3; c++) begin
            nxt();
            chk("to_pre", to, 0);
        end
        nxt();
        chk("to_pulse", to, 1);
        chk("to_err", m_err[0], 1);
        chk("to_scyc", s_cyc, 0);
        nxt();
        chk("to_pulse_end", to, 0);
        chk("to_err_end", m_err[0], 0);
        chk("to_stall", m_stall[0], 1);
        chk("to_hold_gnt", gnt, 3'b001);
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        nxt();
        chk("to_idle", gnt, 0);

        // boundary: ack in the cycle the watchdog would fire
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        nxt();
        chk("bd_gnt", gnt, 3'b001);
        for (int c = 1; c <= 3; c++) nxt();
        s_ack = 1'b1; s_stall = 1'b0; s_dmiso = 32'h0BAD_F00D;
        exp_q.push_back(32'h0BAD_F00D);
        #1;
        chk("bd_ack", m_ack[0], 1);
        check_data("bd_data", 0);
        nxt();
        chk("bd_ack_noto", to, 0);
        chk("bd_ack_scyc", s_cyc, 1);
        s_ack = 1'b0; s_dmiso = '0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        nxt();
        chk("bd_ack_idle", gnt, 0);

        // boundary: master drops cyc in the cycle the watchdog would fire
        s_stall = 1'b1;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
        nxt();
        chk("bd_drop_gnt", gnt, 3'b001);
        for (int c = 1; c <= 3; c++) nxt();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        nxt();
        chk("bd_drop_noto", to, 0);
        chk("bd_drop_idle", gnt, 0);
        chk("bd_drop_scyc", s_cyc, 0);
        nxt();
        chk("bd_drop_noto2", to, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
